// File: rtl/dma_pkg.sv
// dma_pkg: definitions shared by the DMA bus arbiter, its sub-modules and the
// DMA-side models.
//   dma_state_e      arbiter FSM state (3-bit encoding)
//   DMA_XFER_CYCLES  granted cycles a nominal block transfer takes
//   DMA_FIXED_ADDR   fixed device buffer address used by the DMA engine
//   state_*          decode helpers naming what each state drives
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ARB     = 3'd2,
        ST_GRANT   = 3'd3,
        ST_RELEASE = 3'd4
    } dma_state_e;

    localparam int          DMA_XFER_CYCLES = 12;
    localparam logic [15:0] DMA_FIXED_ADDR  = 16'h01f4;

    // cmd is held from the start command until the DMA has been granted and
    // finished; it drops as soon as the arbiter starts releasing the bus.
    function automatic logic state_drives_cmd(input dma_state_e s);
        return (s == ST_CMD) || (s == ST_ARB) || (s == ST_GRANT);
    endfunction

    // The CPU is held off from arbitration until the DMA has let go of BR.
    function automatic logic state_stalls_cpu(input dma_state_e s);
        return (s == ST_ARB) || (s == ST_GRANT) || (s == ST_RELEASE);
    endfunction

endpackage

// File: rtl/dma_arb_timeout.sv
// dma_arb_timeout: saturating cycle counter guarding the CMD and GRANT phases.
//   CLK      in   system clock
//   reset_n  in   synchronous active-low reset
//   clr      in   force the count back to zero (has priority over en)
//   en       in   count this cycle
//   expired  out  count has reached LIMIT-1 (the LIMIT-th counted cycle)
// The count stops at LIMIT-1 and never wraps, so expired stays asserted for as
// long as the counter is enabled and not cleared.
module dma_arb_timeout #(
    parameter int LIMIT = 32,
    parameter int CNT_W = 6
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: sequences the DMA engine and shares the single memory bus
// between the CPU and the DMA.
//   CLK           in   system clock, all state updates on posedge
//   reset_n       in   synchronous active-low reset
//   ext_req       in   device "block ready" strobe
//   cpu_mem_busy  in   CPU memory access in flight this cycle
//   BR            in   bus request from the DMA
//   dma_int       in   DMA end-of-transfer strobe (1 cycle)
//   cmd           out  start/hold command to the DMA
//   BG            out  bus grant to the DMA
//   cpu_stall     out  CPU must not start a new memory access
//   done_irq      out  one-cycle completion pulse
//   abort_irq     out  one-cycle timeout / protocol-error pulse
//   busy          out  arbiter not idle (decoded from the state register)
// Build option: define DMA_ARB_STATS_EN to add saturating statistics
// counters (completed, aborted, CPU stall cycles, merged requests), readable
// hierarchically only.
//
// Handshake: cmd asks the DMA to start; the DMA answers with BR and holds it
// for the whole transfer. BG is given only once the CPU has no access in
// flight, and stays high until dma_int (or a timeout / BR drop). After BG
// falls the arbiter waits for BR to drop before going idle and raising the
// interrupt, so a new transfer never overlaps the tail of the previous one.
module dma_bus_arbiter
    import dma_pkg::*;
#(
    parameter int WORD_SIZE     = 16,
    parameter int GRANT_TIMEOUT = 32,
    parameter int CNT_W         = 6
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic ext_req,
    input  logic cpu_mem_busy,
    input  logic BR,
    input  logic dma_int,
    output logic cmd,
    output logic BG,
    output logic cpu_stall,
    output logic done_irq,
    output logic abort_irq,
    output logic busy
);

    if (GRANT_TIMEOUT < DMA_XFER_CYCLES + 1) begin : g_bad_timeout
        $error("GRANT_TIMEOUT must exceed a nominal transfer length");
    end
    if ((1 << CNT_W) <= GRANT_TIMEOUT) begin : g_bad_cnt_w
        $error("CNT_W too narrow for GRANT_TIMEOUT");
    end
    if (WORD_SIZE < 1) begin : g_bad_word
        $error("WORD_SIZE must be positive");
    end

    dma_state_e state;
    dma_state_e next_state;
    logic       pending;
    logic       abort_flag;
    logic       next_abort;
    logic       tmo_en;
    logic       tmo_expired;
    logic       leave_release;

    // The counter only runs in the two phases that can time out; every
    // other state holds it at zero, so entry to CMD or GRANT starts from 0.
    assign tmo_en = (state == ST_CMD) || (state == ST_GRANT);

    dma_arb_timeout #(
        .LIMIT (GRANT_TIMEOUT),
        .CNT_W (CNT_W)
    ) u_timeout (
        .CLK     (CLK),
        .reset_n (reset_n),
        .clr     (!tmo_en),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        next_state = state;
        next_abort = abort_flag;
        case (state)
            ST_IDLE: begin
                if (pending) next_state = ST_CMD;
            end
            ST_CMD: begin
                if (BR) begin
                    next_state = ST_ARB;
                end else if (tmo_expired) begin
                    next_state = ST_RELEASE;
                    next_abort = 1'b1;
                end
            end
            ST_ARB: begin
                // The CPU's in-flight access always completes first.
                if (!cpu_mem_busy) next_state = ST_GRANT;
            end
            ST_GRANT: begin
                // Completion beats a simultaneous timeout; losing BR early
                // is a protocol error and takes the abort path.
                if (dma_int) begin
                    next_state = ST_RELEASE;
                    next_abort = 1'b0;
                end else if (!BR || tmo_expired) begin
                    next_state = ST_RELEASE;
                    next_abort = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!BR) next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign leave_release = (state == ST_RELEASE) && (next_state == ST_IDLE);

    // Outputs are registered from the next state so they line up with the
    // state they belong to.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            pending    <= 1'b0;
            abort_flag <= 1'b0;
            cmd        <= 1'b0;
            BG         <= 1'b0;
            cpu_stall  <= 1'b0;
            done_irq   <= 1'b0;
            abort_irq  <= 1'b0;
        end else begin
            state      <= next_state;
            // Leaving IDLE consumes the request; a strobe in that same cycle
            // re-arms it, further strobes while armed are merged.
            pending    <= ext_req | (pending & (state != ST_IDLE));
            abort_flag <= next_abort;
            cmd        <= state_drives_cmd(next_state);
            BG         <= (next_state == ST_GRANT);
            cpu_stall  <= state_stalls_cpu(next_state);
            done_irq   <= leave_release && !abort_flag;
            abort_irq  <= leave_release && abort_flag;
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef DMA_ARB_STATS_EN
    logic [WORD_SIZE-1:0] stat_done;
    logic [WORD_SIZE-1:0] stat_abort;
    logic [WORD_SIZE-1:0] stat_stall;
    logic [WORD_SIZE-1:0] stat_merged;

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            stat_done   <= '0;
            stat_abort  <= '0;
            stat_stall  <= '0;
            stat_merged <= '0;
        end else begin
            if (leave_release && !abort_flag && (stat_done != '1))
                stat_done <= stat_done + WORD_SIZE'(1);
            if (leave_release && abort_flag && (stat_abort != '1))
                stat_abort <= stat_abort + WORD_SIZE'(1);
            if (cpu_stall && (stat_stall != '1))
                stat_stall <= stat_stall + WORD_SIZE'(1);
            if (ext_req && pending && (stat_merged != '1))
                stat_merged <= stat_merged + WORD_SIZE'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: a contention vector table, hand-written corner
// sequences driven through a behavioural DMA, and a randomized run, all
// checked against a transfer-level reference model.
module tb_dma_bus_arbiter;
    import dma_pkg::*;

    localparam int GT = 32;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic reset_n = 1'b0;
    logic ext_req = 1'b0;
    logic cpu_mem_busy = 1'b0;
    logic BR = 1'b0;
    logic dma_int = 1'b0;
    logic cmd, BG, cpu_stall, done_irq, abort_irq, busy;

    always #5 CLK = ~CLK;

    dma_bus_arbiter #(
        .WORD_SIZE     (16),
        .GRANT_TIMEOUT (GT),
        .CNT_W         (6)
    ) dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .ext_req      (ext_req),
        .cpu_mem_busy (cpu_mem_busy),
        .BR           (BR),
        .dma_int      (dma_int),
        .cmd          (cmd),
        .BG           (BG),
        .cpu_stall    (cpu_stall),
        .done_irq     (done_irq),
        .abort_irq    (abort_irq),
        .busy         (busy)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase of the current transfer, how many cycles it has spent in that
    // phase (1 = first cycle), whether the ending transfer failed, and the
    // pulses due in the present cycle.
    localparam int P_IDLE = 0, P_CMD = 1, P_ARB = 2, P_GRANT = 3, P_REL = 4;
    int   m_ph;
    int   m_age;
    bit   m_pend;
    bit   m_fail;
    bit   m_done_now;
    bit   m_abort_now;
    int   m_merged;

    task automatic m_reset();
        m_ph = P_IDLE; m_age = 1; m_pend = 0; m_fail = 0;
        m_done_now = 0; m_abort_now = 0; m_merged = 0;
    endtask

    task automatic m_step(input bit ext, input bit cpu, input bit br, input bit dint);
        int nph;
        nph = m_ph;
        m_done_now = 0;
        m_abort_now = 0;
        if (m_ph == P_IDLE && m_pend) nph = P_CMD;
        if (m_ph == P_CMD) begin
            if (br) nph = P_ARB;
            else if (m_age >= GT) begin nph = P_REL; m_fail = 1; end
        end
        if (m_ph == P_ARB && !cpu) nph = P_GRANT;
        if (m_ph == P_GRANT) begin
            if (dint) begin nph = P_REL; m_fail = 0; end
            else if (!br || m_age >= GT) begin nph = P_REL; m_fail = 1; end
        end
        if (m_ph == P_REL && !br) begin
            nph = P_IDLE;
            m_done_now = !m_fail;
            m_abort_now = m_fail;
        end
        if (ext && m_pend) m_merged++;
        if (ext) m_pend = 1;
        else if (m_ph == P_IDLE) m_pend = 0;
        m_age = (nph == m_ph) ? m_age + 1 : 1;
        m_ph = nph;
    endtask

    // ---------------- behavioural DMA + driver ----------------
    int dma_len;   // dma_int on this granted cycle; 0 = never
    int br_hold;   // cycles BR lingers after cmd drops
    int drop_at;   // drop BR on this granted cycle; 0 = never
    bit br_mute;   // DMA never answers cmd
    int bg_cnt;
    int hold_left;

    int cyc, first_cmd, first_bg, bg_total, cmd_total, done_total, abort_total;

    task automatic clear_obs();
        cyc = 0; first_cmd = -1; first_bg = -1;
        bg_total = 0; cmd_total = 0; done_total = 0; abort_total = 0;
    endtask

    // Called just after a negedge: compare this cycle's outputs, pick this
    // cycle's inputs, advance the model, move to the next negedge.
    task automatic cycle(input bit ext, input bit cpu, input bit rst_n);
        bit br, dint;
        check("cmd", cmd, int'(m_ph == P_CMD || m_ph == P_ARB || m_ph == P_GRANT));
        check("BG", BG, int'(m_ph == P_GRANT));
        check("cpu_stall", cpu_stall, int'(m_ph == P_ARB || m_ph == P_GRANT || m_ph == P_REL));
        check("done_irq", done_irq, int'(m_done_now));
        check("abort_irq", abort_irq, int'(m_abort_now));
        check("busy", busy, int'(m_ph != P_IDLE));
        if (cmd && first_cmd < 0) first_cmd = cyc;
        if (BG && first_bg < 0) first_bg = cyc;
        bg_total += int'(BG);
        cmd_total += int'(cmd);
        done_total += int'(done_irq);
        abort_total += int'(abort_irq);

        if (BG) bg_cnt++; else bg_cnt = 0;
        dint = BG && (dma_len != 0) && (bg_cnt == dma_len);
        if (br_mute) br = 0;
        else if (cmd) begin
            br = !(BG && drop_at != 0 && bg_cnt >= drop_at);
            hold_left = br_hold;
        end else if (hold_left > 0) begin
            br = 1;
            hold_left--;
        end else br = 0;

        ext_req = ext; cpu_mem_busy = cpu; BR = br; dma_int = dint; reset_n = rst_n;
        if (!rst_n) m_reset();
        else m_step(ext, cpu, br, dint);
        cyc++;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic start_seq(input int len, input int hold, input int drop, input bit mute);
        dma_len = len; br_hold = hold; drop_at = drop; br_mute = mute;
        bg_cnt = 0; hold_left = 0;
        ext_req = 0; cpu_mem_busy = 0; BR = 0; dma_int = 0; reset_n = 0;
        @(posedge CLK);
        @(negedge CLK);
        reset_n = 1;
        m_reset();
        clear_obs();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       ext;
        logic       cpu;
        logic       br;
        logic       dint;
        logic [5:0] exp;   // {cmd, BG, cpu_stall, done_irq, abort_irq, busy}
    } vec_t;
    vec_t tbl[14];

    initial begin
        int reset_cmd_mark;

        // CPU contention with a DMA that is slow to drop BR.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b100001};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b101001};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b101001};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b101001};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b101001};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b101001};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b111001};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b111001};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b001001};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b001001};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000100};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};

        dma_len = DMA_XFER_CYCLES; br_hold = 0; drop_at = 0; br_mute = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);

        // Basic transfer.
        start_seq(DMA_XFER_CYCLES, 0, 0, 0);
        cycle(1, 0, 1);
        repeat (24) cycle(0, 0, 1);
        check("basic_first_cmd", first_cmd, 2);
        check("basic_first_bg", first_bg, 4);
        check("basic_bg_cycles", bg_total, DMA_XFER_CYCLES);
        check("basic_done", done_total, 1);
        check("basic_abort", abort_total, 0);
        check("basic_stall_end", cpu_stall, 0);

        // Contention table.
        start_seq(0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            total++;
            if ({cmd, BG, cpu_stall, done_irq, abort_irq, busy} !== tbl[i].exp) begin
                bad++;
                $display("FAIL tbl[%0d]: got %b expected %b", i,
                         {cmd, BG, cpu_stall, done_irq, abort_irq, busy}, tbl[i].exp);
            end
            ext_req = tbl[i].ext; cpu_mem_busy = tbl[i].cpu;
            BR = tbl[i].br; dma_int = tbl[i].dint;
            @(posedge CLK);
            @(negedge CLK);
        end

        // Grant timeout: the DMA never finishes.
        start_seq(0, 0, 0, 0);
        cycle(1, 0, 1);
        repeat (50) cycle(0, 0, 1);
        check("tmo_bg_cycles", bg_total, GT);
        check("tmo_abort", abort_total, 1);
        check("tmo_done", done_total, 0);
        check("tmo_busy_end", busy, 0);

        // Simultaneous dma_int and timeout: completion wins.
        start_seq(GT, 0, 0, 0);
        cycle(1, 0, 1);
        repeat (45) cycle(0, 0, 1);
        check("sim_bg_cycles", bg_total, GT);
        check("sim_done", done_total, 1);
        check("sim_abort", abort_total, 0);

        // CMD timeout: the DMA never raises BR.
        start_seq(DMA_XFER_CYCLES, 0, 0, 1);
        cycle(1, 0, 1);
        repeat (45) cycle(0, 0, 1);
        check("cmdtmo_cmd_cycles", cmd_total, GT);
        check("cmdtmo_bg", bg_total, 0);
        check("cmdtmo_abort", abort_total, 1);

        // BR dropped early during GRANT.
        start_seq(DMA_XFER_CYCLES, 0, 3, 0);
        cycle(1, 0, 1);
        repeat (20) cycle(0, 0, 1);
        check("drop_bg_cycles", bg_total, 3);
        check("drop_abort", abort_total, 1);
        check("drop_done", done_total, 0);

        // Merged requests: three strobes inside one grant give one extra transfer.
        start_seq(DMA_XFER_CYCLES, 0, 0, 0);
        for (int c = 0; c < 60; c++) cycle(c == 0 || c == 5 || c == 7 || c == 9, 0, 1);
        check("merge_done", done_total, 2);
        check("merge_bg_cycles", bg_total, 2 * DMA_XFER_CYCLES);
        check("merge_model_count", m_merged, 2);
`ifdef DMA_ARB_STATS_EN
        check("stat_merged", int'(dut.stat_merged), m_merged);
        check("stat_done", int'(dut.stat_done), done_total);
        check("stat_abort", int'(dut.stat_abort), 0);
`endif

        // Reset at granted cycle 5 with a request merged in beforehand.
        start_seq(DMA_XFER_CYCLES, 0, 0, 0);
        for (int c = 0; c < 9; c++) cycle(c == 0 || c == 6, 0, c != 8);
        check("rst_bg_before", bg_total, 5);
        check("rst_after_cmd", cmd, 0);
        check("rst_after_bg", BG, 0);
        check("rst_after_stall", cpu_stall, 0);
        reset_cmd_mark = cmd_total;
        repeat (12) cycle(0, 0, 1);
        check("rst_pending_cleared", cmd_total - reset_cmd_mark, 0);
        check("rst_no_irq", done_total + abort_total, 0);

        // Randomized traffic against the model.
        start_seq(DMA_XFER_CYCLES, 0, 0, 0);
        for (int chunk = 0; chunk < 25; chunk++) begin
            dma_len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 40));
            br_hold = int'($urandom_range(0, 3));
            drop_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 20)) : 0;
            br_mute = ($urandom_range(0, 15) == 0);
            for (int c = 0; c < 120; c++)
                cycle($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 399) != 0);
        end
        br_mute = 0;
        repeat (100) cycle(0, 0, 1);
        check("rand_idle_end", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
